// File: rtl/regfile_pkg.sv
// Shared defaults and helpers for the parametrised register file and its scoreboard.
package regfile_pkg;

    localparam int DEF_DATA_W   = 8;
    localparam int DEF_NUM_REGS = 8;

    // Address width for a given depth; a single-register file still needs one address bit.
    function automatic int calc_addr_w(input int num_regs);
        return (num_regs < 2) ? 1 : $clog2(num_regs);
    endfunction

    typedef logic [DEF_NUM_REGS-1:0] busy_vec_t;

endpackage

// File: rtl/reg_scoreboard.sv
// Pending-write scoreboard: one busy bit per register, reservation handshake and busy count.
module reg_scoreboard
    import regfile_pkg::*;
#(
    parameter int NUM_REGS = DEF_NUM_REGS,
    parameter int ADDR_W   = calc_addr_w(NUM_REGS),
    parameter int ZERO_REG = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic              rsv_valid,
    input  logic [ADDR_W-1:0] rsv_addr,
    input  logic [ADDR_W-1:0] rd_addr_a,
    input  logic [ADDR_W-1:0] rd_addr_b,
    output logic              rsv_ok,
    output logic              rd_busy_a,
    output logic              rd_busy_b,
    output logic [ADDR_W:0]   busy_count
);

    logic [NUM_REGS-1:0] busy_q;
    logic [NUM_REGS-1:0] busy_d;
    logic [ADDR_W:0]     busy_count_q;
    logic [ADDR_W:0]     busy_count_d;
    logic                rsv_is_zero;
    logic                rsv_ok_c;

    // A reservation is granted if the target is free or is being written back this cycle.
    always_comb begin
        rsv_is_zero = (ZERO_REG != 0) && (rsv_addr == '0);
        rsv_ok_c    = 1'b0;
        if (!rst) begin
            rsv_ok_c = rsv_valid &&
                       (rsv_is_zero || !busy_q[rsv_addr] || (we && (wr_addr == rsv_addr)));
        end
    end

    always_comb begin
        busy_d = busy_q;
        if (we) begin
            busy_d[wr_addr] = 1'b0;
        end
        if (rsv_ok_c && !rsv_is_zero) begin
            busy_d[rsv_addr] = 1'b1;
        end
        if (ZERO_REG != 0) begin
            busy_d[0] = 1'b0;
        end
    end

    always_comb begin
        busy_count_d = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            busy_count_d = busy_count_d + (ADDR_W+1)'(busy_d[i]);
        end
    end

    // A writeback to the register being read hides its busy bit in the same cycle.
    always_comb begin
        rd_busy_a = 1'b0;
        rd_busy_b = 1'b0;
        if (!rst) begin
            rd_busy_a = busy_q[rd_addr_a] && !(we && (wr_addr == rd_addr_a));
            rd_busy_b = busy_q[rd_addr_b] && !(we && (wr_addr == rd_addr_b));
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q       <= '0;
            busy_count_q <= '0;
        end else begin
            busy_q       <= busy_d;
            busy_count_q <= busy_count_d;
        end
    end

    assign rsv_ok     = rsv_ok_c;
    assign busy_count = busy_count_q;

endmodule

// File: rtl/reg_file_sb.sv
// Register file with two combinational read ports, write-to-read bypass and an
// optional hard-wired zero register; hazard tracking lives in reg_scoreboard.
module reg_file_sb
    import regfile_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int NUM_REGS = DEF_NUM_REGS,
    parameter int ADDR_W   = calc_addr_w(NUM_REGS),
    parameter int ZERO_REG = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] rd_addr_a,
    input  logic [ADDR_W-1:0] rd_addr_b,
    output logic [DATA_W-1:0] rd_data_a,
    output logic [DATA_W-1:0] rd_data_b,
    output logic              rd_busy_a,
    output logic              rd_busy_b,
    input  logic              we,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rsv_valid,
    input  logic [ADDR_W-1:0] rsv_addr,
    output logic              rsv_ok,
    output logic [ADDR_W:0]   busy_count
);

    logic [DATA_W-1:0] regs_q [NUM_REGS];
    logic [DATA_W-1:0] regs_d [NUM_REGS];
    logic              wr_is_zero;
    logic              rd_a_zero;
    logic              rd_b_zero;

    always_comb begin
        wr_is_zero = (ZERO_REG != 0) && (wr_addr == '0);
        regs_d     = regs_q;
        if (we && !wr_is_zero) begin
            regs_d[wr_addr] = wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            regs_q <= regs_d;
        end
    end

    // The zero register masks ahead of the bypass so a dropped write never shows up.
    always_comb begin
        rd_a_zero = (ZERO_REG != 0) && (rd_addr_a == '0);
        rd_b_zero = (ZERO_REG != 0) && (rd_addr_b == '0);
        rd_data_a = '0;
        rd_data_b = '0;
        if (!rst) begin
            if (rd_a_zero) begin
                rd_data_a = '0;
            end else if (we && (wr_addr == rd_addr_a)) begin
                rd_data_a = wr_data;
            end else begin
                rd_data_a = regs_q[rd_addr_a];
            end
            if (rd_b_zero) begin
                rd_data_b = '0;
            end else if (we && (wr_addr == rd_addr_b)) begin
                rd_data_b = wr_data;
            end else begin
                rd_data_b = regs_q[rd_addr_b];
            end
        end
    end

    reg_scoreboard #(
        .NUM_REGS (NUM_REGS),
        .ADDR_W   (ADDR_W),
        .ZERO_REG (ZERO_REG)
    ) u_scoreboard (
        .clk        (clk),
        .rst        (rst),
        .we         (we),
        .wr_addr    (wr_addr),
        .rsv_valid  (rsv_valid),
        .rsv_addr   (rsv_addr),
        .rd_addr_a  (rd_addr_a),
        .rd_addr_b  (rd_addr_b),
        .rsv_ok     (rsv_ok),
        .rd_busy_a  (rd_busy_a),
        .rd_busy_b  (rd_busy_b),
        .busy_count (busy_count)
    );

endmodule

// File: tb/tb_reg_file_sb.sv
// Directed bench for reg_file_sb: 8x8 with and without the zero register, plus a 16x16 instance.
module tb_reg_file_sb;

    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] rd_addr_a, rd_addr_b, wr_addr, rsv_addr;
    logic [7:0] wr_data;
    logic       we, rsv_valid;

    logic [7:0] z_rd_data_a, z_rd_data_b, n_rd_data_a, n_rd_data_b;
    logic       z_rd_busy_a, z_rd_busy_b, n_rd_busy_a, n_rd_busy_b;
    logic       z_rsv_ok, n_rsv_ok;
    logic [3:0] z_busy_count, n_busy_count;

    logic [3:0]  w_rd_addr_a, w_rd_addr_b, w_wr_addr, w_rsv_addr;
    logic [15:0] w_wr_data, w_rd_data_a, w_rd_data_b;
    logic        w_we, w_rsv_valid, w_rd_busy_a, w_rd_busy_b, w_rsv_ok;
    logic [4:0]  w_busy_count;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    reg_file_sb #(.DATA_W(8), .NUM_REGS(8), .ZERO_REG(1)) dut_z (
        .clk(clk), .rst(rst), .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
        .rd_data_a(z_rd_data_a), .rd_data_b(z_rd_data_b),
        .rd_busy_a(z_rd_busy_a), .rd_busy_b(z_rd_busy_b),
        .we(we), .wr_addr(wr_addr), .wr_data(wr_data),
        .rsv_valid(rsv_valid), .rsv_addr(rsv_addr), .rsv_ok(z_rsv_ok),
        .busy_count(z_busy_count));

    reg_file_sb #(.DATA_W(8), .NUM_REGS(8), .ZERO_REG(0)) dut_n (
        .clk(clk), .rst(rst), .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
        .rd_data_a(n_rd_data_a), .rd_data_b(n_rd_data_b),
        .rd_busy_a(n_rd_busy_a), .rd_busy_b(n_rd_busy_b),
        .we(we), .wr_addr(wr_addr), .wr_data(wr_data),
        .rsv_valid(rsv_valid), .rsv_addr(rsv_addr), .rsv_ok(n_rsv_ok),
        .busy_count(n_busy_count));

    reg_file_sb #(.DATA_W(16), .NUM_REGS(16), .ZERO_REG(0)) dut_w (
        .clk(clk), .rst(rst), .rd_addr_a(w_rd_addr_a), .rd_addr_b(w_rd_addr_b),
        .rd_data_a(w_rd_data_a), .rd_data_b(w_rd_data_b),
        .rd_busy_a(w_rd_busy_a), .rd_busy_b(w_rd_busy_b),
        .we(w_we), .wr_addr(w_wr_addr), .wr_data(w_wr_data),
        .rsv_valid(w_rsv_valid), .rsv_addr(w_rsv_addr), .rsv_ok(w_rsv_ok),
        .busy_count(w_busy_count));

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        we        = 1'b0;
        rsv_valid = 1'b0;
        w_we        = 1'b0;
        w_rsv_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        we = 1'b1; wr_addr = 3'd3; wr_data = 8'h77;
        rsv_valid = 1'b1; rsv_addr = 3'd4;
        rd_addr_a = 3'd3; rd_addr_b = 3'd4;
        #1;
        checks++; if (n_rd_data_a !== 8'h00) begin failures++; $display("[TB] FAIL rst_forced_data got=%h exp=00", n_rd_data_a); end
        checks++; if (n_rsv_ok !== 1'b0) begin failures++; $display("[TB] FAIL rst_forced_rsv_ok got=%b exp=0", n_rsv_ok); end
        step();
        step();
        rst = 1'b0;
        idle();
        #1;
        for (int i = 0; i < 8; i++) begin
            rd_addr_a = 3'(i); rd_addr_b = 3'(i);
            #1;
            checks++; if (z_rd_data_a !== 8'h00) begin failures++; $display("[TB] FAIL reset_data_z r%0d got=%h exp=00", i, z_rd_data_a); end
            checks++; if (n_rd_data_b !== 8'h00) begin failures++; $display("[TB] FAIL reset_data_n r%0d got=%h exp=00", i, n_rd_data_b); end
            checks++; if (n_rd_busy_a !== 1'b0) begin failures++; $display("[TB] FAIL reset_busy r%0d got=%b exp=0", i, n_rd_busy_a); end
        end
        checks++; if (n_busy_count !== 4'd0) begin failures++; $display("[TB] FAIL reset_count got=%0d exp=0", n_busy_count); end
        checks++; if (w_busy_count !== 5'd0) begin failures++; $display("[TB] FAIL reset_count_w got=%0d exp=0", w_busy_count); end
    endtask

    task automatic test_write_bypass();
        we = 1'b1; wr_addr = 3'd3; wr_data = 8'hA5;
        rd_addr_a = 3'd3; rd_addr_b = 3'd4;
        #1;
        checks++; if (z_rd_data_a !== 8'hA5) begin failures++; $display("[TB] FAIL bypass_a got=%h exp=a5", z_rd_data_a); end
        checks++; if (z_rd_data_b !== 8'h00) begin failures++; $display("[TB] FAIL no_bypass_b got=%h exp=00", z_rd_data_b); end
        step();
        idle();
        #1;
        checks++; if (z_rd_data_a !== 8'hA5) begin failures++; $display("[TB] FAIL stored_a got=%h exp=a5", z_rd_data_a); end
    endtask

    task automatic test_reserve();
        rsv_valid = 1'b1; rsv_addr = 3'd5; rd_addr_b = 3'd5;
        #1;
        checks++; if (n_rsv_ok !== 1'b1) begin failures++; $display("[TB] FAIL rsv_first_ok got=%b exp=1", n_rsv_ok); end
        checks++; if (n_rd_busy_b !== 1'b0) begin failures++; $display("[TB] FAIL rsv_same_cycle_busy got=%b exp=0", n_rd_busy_b); end
        step();
        rsv_valid = 1'b0;
        #1;
        checks++; if (n_rd_busy_b !== 1'b1) begin failures++; $display("[TB] FAIL rsv_busy got=%b exp=1", n_rd_busy_b); end
        checks++; if (n_busy_count !== 4'd1) begin failures++; $display("[TB] FAIL rsv_count got=%0d exp=1", n_busy_count); end
        rsv_valid = 1'b1;
        #1;
        checks++; if (n_rsv_ok !== 1'b0) begin failures++; $display("[TB] FAIL rsv_again_reject got=%b exp=0", n_rsv_ok); end
        step();
        rsv_valid = 1'b0;
        #1;
        checks++; if (n_busy_count !== 4'd1) begin failures++; $display("[TB] FAIL rsv_again_count got=%0d exp=1", n_busy_count); end
        we = 1'b1; wr_addr = 3'd5; wr_data = 8'h3C;
        #1;
        checks++; if (n_rd_busy_b !== 1'b0) begin failures++; $display("[TB] FAIL wb_busy_bypass got=%b exp=0", n_rd_busy_b); end
        checks++; if (n_rd_data_b !== 8'h3C) begin failures++; $display("[TB] FAIL wb_data_bypass got=%h exp=3c", n_rd_data_b); end
        checks++; if (n_busy_count !== 4'd1) begin failures++; $display("[TB] FAIL wb_count_before got=%0d exp=1", n_busy_count); end
        step();
        idle();
        #1;
        checks++; if (n_busy_count !== 4'd0) begin failures++; $display("[TB] FAIL wb_count_after got=%0d exp=0", n_busy_count); end
        checks++; if (n_rd_busy_b !== 1'b0) begin failures++; $display("[TB] FAIL wb_busy_after got=%b exp=0", n_rd_busy_b); end
    endtask

    task automatic test_write_reserve_same();
        rsv_valid = 1'b1; rsv_addr = 3'd2;
        step();
        we = 1'b1; wr_addr = 3'd2; wr_data = 8'h5A;
        rsv_valid = 1'b1; rsv_addr = 3'd2;
        #1;
        checks++; if (n_rsv_ok !== 1'b1) begin failures++; $display("[TB] FAIL wr_rsv_ok got=%b exp=1", n_rsv_ok); end
        step();
        idle();
        rd_addr_a = 3'd2;
        #1;
        checks++; if (n_rd_data_a !== 8'h5A) begin failures++; $display("[TB] FAIL wr_rsv_data got=%h exp=5a", n_rd_data_a); end
        checks++; if (n_rd_busy_a !== 1'b1) begin failures++; $display("[TB] FAIL wr_rsv_busy got=%b exp=1", n_rd_busy_a); end
        checks++; if (z_busy_count !== 4'd1) begin failures++; $display("[TB] FAIL wr_rsv_count got=%0d exp=1", z_busy_count); end
        we = 1'b1; wr_addr = 3'd2; wr_data = 8'h5A;
        step();
        idle();
        #1;
        checks++; if (n_busy_count !== 4'd0) begin failures++; $display("[TB] FAIL wr_rsv_clear got=%0d exp=0", n_busy_count); end
    endtask

    task automatic test_zero_reg();
        we = 1'b1; wr_addr = 3'd0; wr_data = 8'hFF;
        rsv_valid = 1'b1; rsv_addr = 3'd0;
        rd_addr_a = 3'd0; rd_addr_b = 3'd0;
        #1;
        checks++; if (z_rsv_ok !== 1'b1) begin failures++; $display("[TB] FAIL zero_rsv_ok got=%b exp=1", z_rsv_ok); end
        checks++; if (z_rd_data_a !== 8'h00) begin failures++; $display("[TB] FAIL zero_no_bypass got=%h exp=00", z_rd_data_a); end
        checks++; if (n_rd_data_a !== 8'hFF) begin failures++; $display("[TB] FAIL nonzero_bypass got=%h exp=ff", n_rd_data_a); end
        step();
        idle();
        #1;
        checks++; if (z_rd_data_b !== 8'h00) begin failures++; $display("[TB] FAIL zero_stored got=%h exp=00", z_rd_data_b); end
        checks++; if (z_rd_busy_a !== 1'b0) begin failures++; $display("[TB] FAIL zero_busy got=%b exp=0", z_rd_busy_a); end
        checks++; if (z_busy_count !== 4'd0) begin failures++; $display("[TB] FAIL zero_count got=%0d exp=0", z_busy_count); end
        checks++; if (n_rd_data_a !== 8'hFF) begin failures++; $display("[TB] FAIL nonzero_stored got=%h exp=ff", n_rd_data_a); end
        checks++; if (n_busy_count !== 4'd1) begin failures++; $display("[TB] FAIL nonzero_count got=%0d exp=1", n_busy_count); end
        we = 1'b1; wr_addr = 3'd0; wr_data = 8'hFF;
        step();
        idle();
        #1;
        checks++; if (n_busy_count !== 4'd0) begin failures++; $display("[TB] FAIL nonzero_clear got=%0d exp=0", n_busy_count); end
    endtask

    task automatic test_reserve_all_and_reset();
        for (int i = 0; i < 8; i++) begin
            rsv_valid = 1'b1; rsv_addr = 3'(i);
            step();
        end
        idle();
        #1;
        checks++; if (n_busy_count !== 4'd8) begin failures++; $display("[TB] FAIL all_count got=%0d exp=8", n_busy_count); end
        checks++; if (z_busy_count !== 4'd7) begin failures++; $display("[TB] FAIL all_count_zero got=%0d exp=7", z_busy_count); end
        rst = 1'b1;
        we = 1'b1; wr_addr = 3'd6; wr_data = 8'h99; rd_addr_a = 3'd6;
        #1;
        checks++; if (n_rd_busy_a !== 1'b0) begin failures++; $display("[TB] FAIL mid_rst_busy_forced got=%b exp=0", n_rd_busy_a); end
        step();
        rst = 1'b0;
        idle();
        #1;
        checks++; if (n_busy_count !== 4'd0) begin failures++; $display("[TB] FAIL mid_rst_count got=%0d exp=0", n_busy_count); end
        checks++; if (n_rd_data_a !== 8'h00) begin failures++; $display("[TB] FAIL mid_rst_write_dropped got=%h exp=00", n_rd_data_a); end
        checks++; if (n_rd_busy_a !== 1'b0) begin failures++; $display("[TB] FAIL mid_rst_busy got=%b exp=0", n_rd_busy_a); end
    endtask

    task automatic test_wide();
        for (int i = 0; i < 16; i++) begin
            w_rsv_valid = 1'b1; w_rsv_addr = 4'(i);
            step();
        end
        idle();
        #1;
        checks++; if (w_busy_count !== 5'd16) begin failures++; $display("[TB] FAIL wide_all_count got=%0d exp=16", w_busy_count); end
        w_we = 1'b1; w_wr_addr = 4'd9; w_wr_data = 16'hBEEF;
        w_rd_addr_a = 4'd9; w_rd_addr_b = 4'd9;
        #1;
        checks++; if (w_rd_data_a !== 16'hBEEF) begin failures++; $display("[TB] FAIL wide_bypass_a got=%h exp=beef", w_rd_data_a); end
        checks++; if (w_rd_data_b !== 16'hBEEF) begin failures++; $display("[TB] FAIL wide_bypass_b got=%h exp=beef", w_rd_data_b); end
        checks++; if (w_rd_busy_b !== 1'b0) begin failures++; $display("[TB] FAIL wide_busy_bypass got=%b exp=0", w_rd_busy_b); end
        step();
        idle();
        w_rd_addr_b = 4'd10;
        #1;
        checks++; if (w_rd_data_a !== 16'hBEEF) begin failures++; $display("[TB] FAIL wide_stored got=%h exp=beef", w_rd_data_a); end
        checks++; if (w_busy_count !== 5'd15) begin failures++; $display("[TB] FAIL wide_count_after got=%0d exp=15", w_busy_count); end
        checks++; if (w_rd_busy_b !== 1'b1) begin failures++; $display("[TB] FAIL wide_other_busy got=%b exp=1", w_rd_busy_b); end
    endtask

    initial begin
        rst = 1'b0;
        we = 1'b0; rsv_valid = 1'b0;
        rd_addr_a = '0; rd_addr_b = '0; wr_addr = '0; rsv_addr = '0; wr_data = '0;
        w_we = 1'b0; w_rsv_valid = 1'b0;
        w_rd_addr_a = '0; w_rd_addr_b = '0; w_wr_addr = '0; w_rsv_addr = '0; w_wr_data = '0;
        step();
        test_reset();
        test_write_bypass();
        test_reserve();
        test_write_reserve_same();
        test_zero_reg();
        test_reserve_all_and_reset();
        test_wide();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
